// File: rtl/fpu_window_buffer.sv
// Sliding-window column buffer for the FPU convolution datapath: shifts in one
// column per accepted transfer, adds optional edge padding and band start/done sequencing.
module fpu_window_buffer #(
    parameter int COL_WIDTH = 10,
    parameter int KERNEL    = 3,
    parameter int PIX_W     = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                pad_en,
    input  logic                                pad_mode,
    input  logic                                col_valid,
    output logic                                col_ready,
    input  logic [COL_WIDTH*PIX_W-1:0]          col_in,
    input  logic                                col_last,
    output logic                                win_valid,
    input  logic                                win_ready,
    output logic [KERNEL*COL_WIDTH*PIX_W-1:0]   win,
    output logic                                busy,
    output logic                                done
);
    localparam int PAD = KERNEL / 2;
    localparam int CB  = COL_WIDTH * PIX_W;
    localparam int FW  = $clog2(KERNEL + 1);
    localparam int PW  = $clog2(PAD + 1);
    localparam logic [FW-1:0] K_CNT = FW'(KERNEL);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [KERNEL-1:0][CB-1:0] win_q, win_nxt;
    logic [FW-1:0]           fill_cnt, fill_nxt, fill_inc;
    logic [PW-1:0]           pad_left, pad_left_nxt;
    logic                    pad_en_q, pad_mode_q;
    logic                    win_valid_nxt;
    logic                    slot_free, accept, consume, insert, first_pad;
    logic [CB-1:0]           shift_col;

    assign win       = win_q;
    assign busy      = (state != IDLE);
    assign slot_free = !win_valid || win_ready;
    assign col_ready = (state == FILL || state == RUN) && slot_free;
    assign accept    = col_valid && col_ready;
    assign consume   = win_valid && win_ready;
    // Synthetic trailing pad columns are pushed through the same shift path as real ones.
    assign insert    = (state == DRAIN) && (pad_left != '0) && slot_free;
    assign first_pad = accept && (fill_cnt == '0) && pad_en_q;
    assign shift_col = insert ? (pad_mode_q ? win_q[KERNEL-1] : '0) : col_in;
    assign fill_inc  = (fill_cnt == K_CNT) ? fill_cnt : fill_cnt + 1'b1;

    always_comb begin
        state_nxt     = state;
        win_nxt       = win_q;
        fill_nxt      = fill_cnt;
        pad_left_nxt  = pad_left;
        win_valid_nxt = win_valid;
        done          = 1'b0;

        if (consume)
            win_valid_nxt = 1'b0;

        if (accept || insert) begin
            if (first_pad) begin
                for (int i = 0; i < KERNEL - 1; i++)
                    if (i >= KERNEL - 1 - PAD)
                        win_nxt[i] = pad_mode_q ? col_in : '0;
                win_nxt[KERNEL-1] = col_in;
                fill_nxt          = FW'(PAD + 1);
            end else begin
                for (int i = 0; i < KERNEL - 1; i++)
                    win_nxt[i] = win_q[i+1];
                win_nxt[KERNEL-1] = shift_col;
                fill_nxt          = fill_inc;
            end
            win_valid_nxt = (fill_nxt == K_CNT);
        end

        if (insert)
            pad_left_nxt = pad_left - 1'b1;

        case (state)
            FILL: begin
                if (accept) begin
                    if (col_last) begin
                        state_nxt    = DRAIN;
                        pad_left_nxt = pad_en_q ? PW'(PAD) : '0;
                    end else if (fill_nxt == K_CNT) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (accept && col_last) begin
                    state_nxt    = DRAIN;
                    pad_left_nxt = pad_en_q ? PW'(PAD) : '0;
                end
            end
            DRAIN: begin
                if (pad_left == '0 && !win_valid) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: ;
        endcase

        // A new band aborts whatever is in flight, including a same-cycle column.
        if (start) begin
            state_nxt     = FILL;
            win_nxt       = '0;
            fill_nxt      = '0;
            pad_left_nxt  = '0;
            win_valid_nxt = 1'b0;
            done          = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win_q      <= '0;
            fill_cnt   <= '0;
            pad_left   <= '0;
            win_valid  <= 1'b0;
            pad_en_q   <= 1'b0;
            pad_mode_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            win_q     <= win_nxt;
            fill_cnt  <= fill_nxt;
            pad_left  <= pad_left_nxt;
            win_valid <= win_valid_nxt;
            if (start) begin
                pad_en_q   <= pad_en;
                pad_mode_q <= pad_mode;
            end
        end
    end
endmodule

// File: tb/tb_fpu_window_buffer.sv
// Randomized bench for fpu_window_buffer: a column-list model builds the expected
// window sequence per band and a scoreboard checks every consumed window.
module tb_fpu_window_buffer;
    localparam int COL_WIDTH = 10;
    localparam int KERNEL    = 3;
    localparam int PIX_W     = 8;
    localparam int PAD       = KERNEL / 2;
    localparam int CB        = COL_WIDTH * PIX_W;
    localparam int WB        = KERNEL * CB;

    logic          clk = 0, rst_n = 0, start = 0, pad_en = 0, pad_mode = 0;
    logic          col_valid = 0, col_last = 0, win_ready = 0;
    logic [CB-1:0] col_in = '0;
    logic          col_ready, win_valid, busy, done;
    logic [WB-1:0] win;

    int checks = 0, errors = 0, cyc = 0;
    logic [CB-1:0] band_cols[$];
    logic [WB-1:0] exp_q[$];

    fpu_window_buffer #(.COL_WIDTH(COL_WIDTH), .KERNEL(KERNEL), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pad_en(pad_en), .pad_mode(pad_mode),
        .col_valid(col_valid), .col_ready(col_ready), .col_in(col_in), .col_last(col_last),
        .win_valid(win_valid), .win_ready(win_ready), .win(win), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic make_cols(input int n, input bit directed, input int base);
        logic [CB-1:0] c;
        logic [7:0]    v;
        band_cols = {};
        for (int i = 0; i < n; i++) begin
            if (directed) begin
                v = 8'(base + i);
                c = {COL_WIDTH{v}};
            end else begin
                for (int p = 0; p < COL_WIDTH; p++)
                    c[p*PIX_W +: PIX_W] = 8'($urandom);
            end
            band_cols.push_back(c);
        end
    endtask

    // Expected windows: every KERNEL-wide slice of the (optionally padded) column list.
    task automatic build_exp(input bit pe, input bit pm);
        logic [CB-1:0] p[$];
        logic [WB-1:0] w;
        int n;
        n = band_cols.size();
        p = {};
        exp_q = {};
        if (pe) for (int i = 0; i < PAD; i++) p.push_back(pm ? band_cols[0] : '0);
        for (int i = 0; i < n; i++) p.push_back(band_cols[i]);
        if (pe) for (int i = 0; i < PAD; i++) p.push_back(pm ? band_cols[n-1] : '0);
        for (int s = 0; s + KERNEL <= p.size(); s++) begin
            for (int k = 0; k < KERNEL; k++) w[k*CB +: CB] = p[s+k];
            exp_q.push_back(w);
        end
    endtask

    // bp: 0 = always ready, 1 = random gaps/backpressure, 2 = stall 5 cycles at first window
    task automatic run_band(input bit pe, input bit pm, input int bp, input int abort_after);
        int n, idx, consumes, last_evt, held;
        bit seen_done, hold, acc, con, no_win;
        logic [WB-1:0] hold_win;
        n = band_cols.size();
        idx = 0; consumes = 0; last_evt = -100; held = 0;
        seen_done = 0; hold = 0; hold_win = '0;
        build_exp(pe, pm);
        no_win = (exp_q.size() == 0);

        @(negedge clk);
        start = 1; pad_en = pe; pad_mode = pm; col_valid = 0; win_ready = 0;
        #1 chk("start_nodone", done, 0);
        @(negedge clk);
        start = 0; pad_en = 1'($urandom); pad_mode = 1'($urandom);

        for (int t = 0; t < 600; t++) begin
            col_valid = (idx < n) && (bp == 1 ? ($urandom_range(3) != 0) : 1'b1);
            col_in    = (idx < n) ? band_cols[idx] : CB'($urandom);
            col_last  = (idx == n - 1);
            if (bp == 1)      win_ready = ($urandom_range(2) != 0);
            else if (bp == 2) win_ready = !(win_valid && held < 5);
            else              win_ready = 1;
            #1;
            if (t == 0) begin
                chk("start_clr_win", win, '0);
                chk("start_clr_valid", win_valid, 0);
            end
            if (hold) begin
                chk("hold_win", win, hold_win);
                chk("hold_valid", win_valid, 1);
            end
            hold = win_valid && !win_ready;
            hold_win = win;
            if (hold) begin
                chk("bp_col_ready", col_ready, 0);
                held++;
            end
            acc = col_valid && col_ready;
            con = win_valid && win_ready;
            if (done) begin
                chk("done_latency", cyc - last_evt, 1);
                chk("done_windows_left", exp_q.size(), 0);
                chk("done_cols_sent", idx, n);
                seen_done = 1;
            end
            if (con) begin
                if (exp_q.size() == 0) chk("extra_window", 1, 0);
                else chk("win", win, exp_q.pop_front());
                consumes++;
                last_evt = cyc;
            end
            if (acc) begin
                idx++;
                if (idx == n && no_win) last_evt = cyc;
            end
            if (seen_done) break;
            if (abort_after > 0 && consumes == abort_after) break;
            @(negedge clk);
        end

        if (abort_after == 0) begin
            chk("done_seen", seen_done, 1);
            @(negedge clk);
            col_valid = 0; win_ready = 0;
            #1;
            chk("done_one_cycle", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_col_ready", col_ready, 0);
        end
    endtask

    initial begin
        int idx;
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_win", win, '0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_col_ready", col_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1;

        make_cols(5, 1, 1); run_band(0, 0, 0, 0);   // {1,2,3},{2,3,4},{3,4,5}
        make_cols(4, 1, 1); run_band(1, 0, 0, 0);   // zero-padded edges
        make_cols(1, 1, 7); run_band(1, 1, 0, 0);   // replicate single column
        make_cols(6, 0, 0); run_band(1, 1, 2, 0);   // stalled first window
        make_cols(8, 0, 0); run_band(0, 0, 0, 3);   // aborted mid-RUN
        make_cols(5, 0, 0); run_band(1, 0, 1, 0);
        make_cols(2, 1, 9); run_band(0, 0, 0, 0);   // short band, no windows

        // Park in DRAIN with a pending window, then hit async reset.
        make_cols(3, 0, 0);
        @(negedge clk);
        start = 1; pad_en = 0; pad_mode = 0; col_valid = 0; win_ready = 0;
        @(negedge clk);
        start = 0;
        idx = 0;
        for (int t = 0; t < 20 && idx < 3; t++) begin
            col_valid = 1; col_in = band_cols[idx]; col_last = (idx == 2);
            #1;
            if (col_ready) idx++;
            @(negedge clk);
        end
        col_valid = 0; col_last = 0;
        #1;
        chk("drain_busy", busy, 1);
        chk("drain_win_valid", win_valid, 1);
        chk("drain_col_ready", col_ready, 0);
        rst_n = 0;
        #1;
        chk("arst_win", win, '0);
        chk("arst_win_valid", win_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_col_ready", col_ready, 0);
        @(negedge clk);
        rst_n = 1;

        for (int b = 0; b < 20; b++) begin
            make_cols($urandom_range(8, 1), 0, 0);
            run_band(1'($urandom), 1'($urandom), $urandom_range(1, 0), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
